// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit path.
//   sched_state_t        : transmit scheduler FSM states
//   ETH_MAX_FRAME_BYTES  : largest untagged Ethernet frame in bytes
//   ETH_WORD_BYTES       : bytes carried per datapath word
package eth_pkg;

    localparam int unsigned ETH_MAX_FRAME_BYTES = 1518;
    localparam int unsigned ETH_WORD_BYTES      = 4;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StLoad,
        StDrain,
        StSend,
        StWaitDone,
        StGap
    } sched_state_t;

endpackage

// File: rtl/eth_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at index ptr, wrapping modulo N_CH, and reports the first requester.
//   req   in   N_CH           request vector
//   ptr   in   $clog2(N_CH)   highest-priority index for this decision
//   grant out  N_CH           one-hot grant, all zero when nothing requests
//   idx   out  $clog2(N_CH)   index of the granted requester
//   any   out  1              at least one requester found
module eth_rr_arbiter #(
    parameter int unsigned N_CH = 4
) (
    input  logic [N_CH-1:0]         req,
    input  logic [$clog2(N_CH)-1:0] ptr,
    output logic [N_CH-1:0]         grant,
    output logic [$clog2(N_CH)-1:0] idx,
    output logic                    any
);

    localparam int unsigned IDX_W = $clog2(N_CH);

    int c;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        for (int i = 0; i < int'(N_CH); i++) begin
            c = int'(ptr) + i;
            if (c >= int'(N_CH)) begin
                c = c - int'(N_CH);
            end
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/eth_tx_scheduler.sv
// Multi-channel transmit scheduler feeding one Ethernet transmitter.
// Round-robin picks a channel holding a complete frame, streams its words to the transmitter
// (truncating at MAX_WORDS and draining the rest), fires tx_send, waits for tx_done and then
// holds off the next grant for an inter-frame gap of IFG_CYCLES cycles.
//   clk_100_mhz, rst        : clock, synchronous active-high reset
//   ch_req/data/valid/last  : per-channel frame sources (data packed c*DATA_W +: DATA_W)
//   ch_ready                : word accepted from the granted channel
//   ch_grant                : one-hot owner of the transmitter
//   ch_done / ch_err        : 1-cycle pulses, frame sent / frame truncated
//   tx_data_in/tx_valid/last_data/tx_ready_to_write : word interface to the transmitter
//   tx_ready_to_send/tx_send/tx_done                : frame start/finish handshake
//   busy, frame_words       : status
module eth_tx_scheduler
    import eth_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_WORDS  = (ETH_MAX_FRAME_BYTES + ETH_WORD_BYTES - 1) / ETH_WORD_BYTES,
    parameter int unsigned IFG_CYCLES = 24
) (
    input  logic                             clk_100_mhz,
    input  logic                             rst,
    input  logic [N_CH-1:0]                  ch_req,
    input  logic [N_CH*DATA_W-1:0]           ch_data,
    input  logic [N_CH-1:0]                  ch_valid,
    input  logic [N_CH-1:0]                  ch_last,
    output logic [N_CH-1:0]                  ch_ready,
    output logic [N_CH-1:0]                  ch_grant,
    output logic [N_CH-1:0]                  ch_done,
    output logic [N_CH-1:0]                  ch_err,
    output logic [DATA_W-1:0]                tx_data_in,
    output logic                             tx_valid,
    output logic                             last_data,
    input  logic                             tx_ready_to_write,
    input  logic                             tx_ready_to_send,
    output logic                             tx_send,
    input  logic                             tx_done,
    output logic                             busy,
    output logic [$clog2(MAX_WORDS+1)-1:0]   frame_words
);

    localparam int unsigned IDX_W = $clog2(N_CH);
    localparam int unsigned FW_W  = $clog2(MAX_WORDS + 1);
    localparam int unsigned CNT_W = $clog2(IFG_CYCLES + 1);

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [N_CH-1:0]  grant_q, grant_d;
    logic [N_CH-1:0]  done_q, done_d;
    logic [N_CH-1:0]  err_q, err_d;
    logic [FW_W-1:0]  fw_q, fw_d;
    logic [CNT_W-1:0] ifg_q, ifg_d;

    logic [N_CH-1:0]   arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic [DATA_W-1:0] g_data;
    logic              g_valid;
    logic              g_last;
    logic              at_limit;

    eth_rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req   (ch_req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Granted-channel view of the source bus.
    assign g_data   = ch_data[gidx_q*DATA_W +: DATA_W];
    assign g_valid  = ch_valid[gidx_q];
    assign g_last   = ch_last[gidx_q];
    // Next accepted word is the last one that fits.
    assign at_limit = (fw_q == FW_W'(MAX_WORDS - 1));

    always_ff @(posedge clk_100_mhz) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            fw_q    <= '0;
            ifg_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fw_q    <= fw_d;
            ifg_q   <= ifg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        fw_d    = fw_q;
        ifg_d   = ifg_q;
        done_d  = '0;
        err_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (|ch_req) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                fw_d = '0;
                if (arb_any) begin
                    grant_d = arb_grant;
                    gidx_d  = arb_idx;
                    ptr_d   = (arb_idx == IDX_W'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
                    state_d = StLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StLoad: begin
                if (g_valid && tx_ready_to_write) begin
                    fw_d = fw_q + 1'b1;
                    if (g_last) begin
                        state_d = StSend;
                    end else if (at_limit) begin
                        err_d   = grant_q;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (g_valid && g_last) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (tx_ready_to_send) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (tx_done) begin
                    done_d  = grant_q;
                    ifg_d   = CNT_W'(IFG_CYCLES - 1);
                    state_d = StGap;
                end
            end
            StGap: begin
                if (ifg_q == '0) begin
                    grant_d = '0;
                    state_d = StIdle;
                end else begin
                    ifg_d = ifg_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ch_ready   = '0;
        tx_data_in = '0;
        tx_valid   = 1'b0;
        last_data  = 1'b0;
        tx_send    = 1'b0;
        unique case (state_q)
            StLoad: begin
                ch_ready[gidx_q] = tx_ready_to_write;
                tx_data_in       = g_data;
                tx_valid         = g_valid;
                last_data        = g_last | at_limit;
            end
            StDrain: begin
                // Discard the overlength tail without presenting it to the transmitter.
                ch_ready[gidx_q] = 1'b1;
            end
            StSend: begin
                tx_send = tx_ready_to_send;
            end
            default: begin
            end
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign ch_grant    = grant_q;
    assign ch_done     = done_q;
    assign ch_err      = err_q;
    assign frame_words = fw_q;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Randomised bench for eth_tx_scheduler: per-channel frame sources, a transmitter model and a
// frame-level scoreboard (expected contents, truncation, round-robin order, gap timing).
module tb_eth_tx_scheduler;

    localparam int N_CH       = 4;
    localparam int DATA_W     = 32;
    localparam int MAX_WORDS  = 8;
    localparam int IFG_CYCLES = 6;
    localparam int MAX_LEN    = 12;
    localparam int FW_W       = $clog2(MAX_WORDS + 1);

    logic                   clk_100_mhz = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        ch_req, ch_valid, ch_last, ch_ready, ch_grant, ch_done, ch_err;
    logic [N_CH*DATA_W-1:0] ch_data;
    logic [DATA_W-1:0]      tx_data_in;
    logic                   tx_valid, last_data, tx_ready_to_write, tx_ready_to_send;
    logic                   tx_send, tx_done, busy;
    logic [FW_W-1:0]        frame_words;

    always #5 clk_100_mhz = ~clk_100_mhz;

    eth_tx_scheduler #(
        .N_CH       (N_CH),
        .DATA_W     (DATA_W),
        .MAX_WORDS  (MAX_WORDS),
        .IFG_CYCLES (IFG_CYCLES)
    ) dut (
        .clk_100_mhz       (clk_100_mhz),
        .rst               (rst),
        .ch_req            (ch_req),
        .ch_data           (ch_data),
        .ch_valid          (ch_valid),
        .ch_last           (ch_last),
        .ch_ready          (ch_ready),
        .ch_grant          (ch_grant),
        .ch_done           (ch_done),
        .ch_err            (ch_err),
        .tx_data_in        (tx_data_in),
        .tx_valid          (tx_valid),
        .last_data         (last_data),
        .tx_ready_to_write (tx_ready_to_write),
        .tx_ready_to_send  (tx_ready_to_send),
        .tx_send           (tx_send),
        .tx_done           (tx_done),
        .busy              (busy),
        .frame_words       (frame_words)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Sources: each channel holds at most one pending frame.
    logic [DATA_W-1:0] src_w [N_CH][MAX_LEN];
    int                src_len [N_CH];
    int                src_idx [N_CH];
    bit                src_has [N_CH];

    // Scoreboard for the frame in flight. phase: 0 none, 1 granted, 2 done and in gap.
    int                phase, g, rr_ptr, cyc, last_done_cyc;
    logic [DATA_W-1:0] exp_w [MAX_LEN];
    int                exp_len, exp_cap, cap_cnt, done_delay;
    bit                sent, src_done, done_real;
    logic [N_CH-1:0]   req_prev, mv, exp_done, exp_err, nxt_done, nxt_err, own;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_grant"}, 64'(ch_grant), 64'd0);
        check_eq({pfx, "_ready"}, 64'(ch_ready), 64'd0);
        check_eq({pfx, "_done"}, 64'(ch_done), 64'd0);
        check_eq({pfx, "_err"}, 64'(ch_err), 64'd0);
        check_eq({pfx, "_tx_valid"}, 64'(tx_valid), 64'd0);
        check_eq({pfx, "_last_data"}, 64'(last_data), 64'd0);
        check_eq({pfx, "_tx_send"}, 64'(tx_send), 64'd0);
        check_eq({pfx, "_tx_data"}, 64'(tx_data_in), 64'd0);
        check_eq({pfx, "_busy"}, 64'(busy), 64'd0);
        check_eq({pfx, "_frame_words"}, 64'(frame_words), 64'd0);
    endtask

    task automatic new_frame(input int c);
        int r;
        r = $urandom_range(0, 3);
        case (r)
            0:       src_len[c] = 1;
            1:       src_len[c] = MAX_WORDS;
            2:       src_len[c] = $urandom_range(MAX_WORDS + 1, MAX_LEN);
            default: src_len[c] = $urandom_range(2, MAX_WORDS - 1);
        endcase
        for (int i = 0; i < MAX_LEN; i++) src_w[c][i] = $urandom;
        src_idx[c] = 0;
        src_has[c] = 1'b1;
    endtask

    task automatic drive_sources();
        for (int c = 0; c < N_CH; c++) begin
            ch_req[c]   = src_has[c];
            ch_valid[c] = src_has[c] && ($urandom_range(0, 3) != 0);
            ch_last[c]  = src_has[c] && (src_idx[c] == src_len[c] - 1);
            ch_data[c*DATA_W +: DATA_W] = src_has[c] ? src_w[c][src_idx[c]] : '0;
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) src_has[c] = 1'b0;
        phase         = 0;
        g             = 0;
        rr_ptr        = 0;
        cap_cnt       = 0;
        exp_len       = 0;
        exp_cap       = 0;
        done_delay    = -1;
        sent          = 1'b0;
        src_done      = 1'b0;
        done_real     = 1'b0;
        last_done_cyc = cyc - 1000;
        mv            = '0;
        exp_done      = '0;
        exp_err       = '0;
        req_prev      = '0;
    endtask

    task automatic step();
        int e;
        int c;
        @(negedge clk_100_mhz);
        cyc++;
        check_eq("ch_done", 64'(ch_done), 64'(exp_done));
        check_eq("ch_err", 64'(ch_err), 64'(exp_err));
        nxt_done = '0;
        nxt_err  = '0;

        if (phase == 0) begin
            if (ch_grant != '0) begin
                e = -1;
                for (int i = 0; i < N_CH; i++) begin
                    c = (rr_ptr + i) % N_CH;
                    if (e < 0 && req_prev[c]) e = c;
                end
                check_eq("grant_order", 64'(ch_grant), (e < 0) ? 64'd0 : (64'd1 << e));
                check_eq("ifg_min", (cyc - last_done_cyc - 1 >= IFG_CYCLES) ? 64'd1 : 64'd0,
                         64'd1);
                g = 0;
                for (int i = N_CH - 1; i >= 0; i--) if (ch_grant[i]) g = i;
                rr_ptr  = (g + 1) % N_CH;
                exp_len = src_has[g] ? src_len[g] : 0;
                exp_cap = (exp_len > MAX_WORDS) ? MAX_WORDS : exp_len;
                for (int i = 0; i < MAX_LEN; i++) exp_w[i] = src_w[g][i];
                cap_cnt    = 0;
                sent       = 1'b0;
                src_done   = 1'b0;
                done_delay = -1;
                done_real  = 1'b0;
                phase      = 1;
            end
        end else if (phase == 2 && ch_grant == '0) begin
            check_eq("gap_len", 64'(cyc - last_done_cyc), 64'(IFG_CYCLES + 1));
            phase = 0;
        end else begin
            check_eq("grant_hold", 64'(ch_grant), 64'd1 << g);
        end

        own = '0;
        if (phase != 0) own[g] = 1'b1;
        check_eq("ready_nongrant", 64'(ch_ready & ~own), 64'd0);
        if (phase != 0) check_eq("busy", 64'(busy), 64'd1);

        if (phase == 1 && !sent) begin
            if (tx_valid) check_eq("ready_mirror", 64'(ch_ready[g]), 64'(tx_ready_to_write));
            if (tx_valid && tx_ready_to_write) begin
                if (cap_cnt < exp_cap) begin
                    check_eq("tx_data", 64'(tx_data_in), 64'(exp_w[cap_cnt]));
                    check_eq("last_data", 64'(last_data),
                             (cap_cnt == exp_cap - 1) ? 64'd1 : 64'd0);
                    if (cap_cnt == MAX_WORDS - 1 && exp_len > MAX_WORDS) nxt_err[g] = 1'b1;
                end else begin
                    check_eq("extra_word", 64'(cap_cnt), 64'(exp_cap));
                end
                cap_cnt++;
            end
            if (tx_send) begin
                check_eq("send_rts", 64'(tx_ready_to_send), 64'd1);
                check_eq("frame_len", 64'(cap_cnt), 64'(exp_cap));
                check_eq("frame_words", 64'(frame_words), 64'(exp_cap));
                check_eq("src_drained", 64'(src_done), 64'd1);
                sent       = 1'b1;
                done_delay = $urandom_range(1, 4);
            end
        end else begin
            check_eq("tx_send_idle", 64'(tx_send), 64'd0);
            check_eq("tx_valid_idle", 64'(tx_valid), 64'd0);
        end

        if (done_real) begin
            nxt_done[g]   = 1'b1;
            phase         = 2;
            last_done_cyc = cyc;
            done_real     = 1'b0;
        end
        mv = ch_valid & ch_ready;
        if (phase == 1 && mv[g] && ch_last[g]) src_done = 1'b1;

        @(posedge clk_100_mhz);
        #1;
        exp_done = nxt_done;
        exp_err  = nxt_err;
        req_prev = ch_req;
        for (int k = 0; k < N_CH; k++) begin
            if (mv[k] && src_has[k]) begin
                src_idx[k]++;
                if (src_idx[k] >= src_len[k]) src_has[k] = 1'b0;
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            if (!src_has[k] && $urandom_range(0, 3) == 0) new_frame(k);
        end
        drive_sources();
        tx_ready_to_write = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 7) == 0) tx_ready_to_send = ~tx_ready_to_send;
        tx_done = 1'b0;
        if (done_delay > 0) begin
            done_delay--;
            if (done_delay == 0) begin
                tx_done    = 1'b1;
                done_real  = 1'b1;
                done_delay = -1;
            end
        end else if (!(phase == 1 && sent) && $urandom_range(0, 15) == 0) begin
            // Stray tx_done while the scheduler is not waiting for one.
            tx_done = 1'b1;
        end
    endtask

    task automatic reset_mid_load();
        int n;
        n = 0;
        while (!(phase == 1 && cap_cnt >= 1 && cap_cnt < exp_cap) && n < 3000) begin
            step();
            n++;
        end
        check_eq("reach_load", (phase == 1 && cap_cnt >= 1 && cap_cnt < exp_cap) ? 64'd1 : 64'd0,
                 64'd1);
        rst = 1'b1;
        @(posedge clk_100_mhz);
        @(negedge clk_100_mhz);
        check_reset_outputs("mid_rst");
        model_reset();
        // All channels request on release: first grant must come from channel 0.
        for (int c = 0; c < N_CH; c++) new_frame(c);
        drive_sources();
        tx_done = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        cyc               = 0;
        rst               = 1'b1;
        ch_req            = '0;
        ch_valid          = '0;
        ch_last           = '0;
        ch_data           = '0;
        tx_ready_to_write = 1'b0;
        tx_ready_to_send  = 1'b0;
        tx_done           = 1'b0;
        model_reset();
        @(posedge clk_100_mhz);
        @(posedge clk_100_mhz);
        @(negedge clk_100_mhz);
        check_reset_outputs("por");
        rst = 1'b0;

        repeat (2500) step();
        reset_mid_load();
        repeat (2500) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
